// File: rtl/ifu_fetch.sv
// Instruction fetch unit: keeps one memory request in flight, holds each fetched word
// until downstream takes it, and handles redirects by dropping stale responses.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err
);

    // state | meaning
    // IDLE  | first cycle after reset, nothing issued
    // REQ   | presenting request at pc
    // WAIT  | request accepted, awaiting response
    // HOLD  | fetched word offered downstream
    // DROP  | awaiting a response made stale by a redirect
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_err;
    logic        r_inst_valid;

    logic        w_req_hs;
    logic        w_rsp_hs;
    logic        w_inst_hs;
    logic        w_fetch_done;
    logic [31:0] w_redirect_pc;

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_rsp_ready = (r_state == S_WAIT) || (r_state == S_DROP);
    assign mem_req_addr  = r_pc;

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_err   = r_inst_err;

    assign w_req_hs      = mem_req_valid & mem_req_ready;
    assign w_rsp_hs      = mem_rsp_valid & mem_rsp_ready;
    assign w_inst_hs     = r_inst_valid & inst_ready;
    assign w_fetch_done  = (r_state == S_WAIT) && w_rsp_hs && !redirect_valid;
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_req_hs) begin
                    w_state_nxt = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_state_nxt = w_rsp_hs ? S_REQ : S_DROP;
                end else if (w_rsp_hs) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || w_inst_hs) begin
                    w_state_nxt = S_REQ;
                end
            end
            // A response consumed here retires the stale request even if a new redirect
            // arrives in the same cycle; otherwise we would wait for a response never coming.
            S_DROP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC & 32'hFFFF_FFFC;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_inst_err   <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_fetch_done) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_fetch_done) begin
                r_inst       <= mem_rsp_data;
                r_inst_pc    <= r_pc;
                r_inst_err   <= mem_rsp_err;
                r_inst_valid <= 1'b1;
            end else if ((r_state == S_HOLD) && (redirect_valid || inst_ready)) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: steps one clock at a time, drives inputs just after
// the rising edge and compares outputs against hand-computed values.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;

    int checks;
    int failures;

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_ready  (mem_rsp_ready),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        mem_rsp_err    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_rsp_ready", {31'b0, mem_rsp_ready}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_err", {31'b0, inst_err}, 32'd0);
        chk("rst_addr", mem_req_addr, 32'h8000_0000);

        // basic fetch
        rst = 1'b0;
        tick();
        chk("b_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("b_req_addr", mem_req_addr, 32'h8000_0000);
        mem_req_ready = 1'b1;
        tick();
        chk("b_wait_rsp_ready", {31'b0, mem_rsp_ready}, 32'd1);
        chk("b_wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0013;
        tick();
        mem_rsp_valid = 1'b0;
        chk("b_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("b_inst", inst, 32'h0000_0013);
        chk("b_inst_pc", inst_pc, 32'h8000_0000);
        chk("b_next_addr", mem_req_addr, 32'h8000_0004);

        // backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
            chk("bp_inst", inst, 32'h0000_0013);
            chk("bp_inst_pc", inst_pc, 32'h8000_0000);
            chk("bp_req_valid", {31'b0, mem_req_valid}, 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("bp_rel_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("bp_rel_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("bp_rel_addr", mem_req_addr, 32'h8000_0004);

        // redirect in WAIT, response three cycles after accept
        tick();
        chk("rw_wait", {31'b0, mem_rsp_ready}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("rw_drop_rsp_ready", {31'b0, mem_rsp_ready}, 32'd1);
        chk("rw_drop_addr", mem_req_addr, 32'h8000_0100);
        tick();
        chk("rw_drop_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rw_drop_inst_valid", {31'b0, inst_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rw_stale_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rw_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("rw_req_addr", mem_req_addr, 32'h8000_0100);
        chk("rw_inst_kept", inst, 32'h0000_0013);

        // access fault
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        chk("f_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("f_inst_err", {31'b0, inst_err}, 32'd1);
        chk("f_inst_pc", inst_pc, 32'h8000_0100);
        chk("f_inst", inst, 32'h1234_5678);
        chk("f_next_addr", mem_req_addr, 32'h8000_0104);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("f_req_addr", mem_req_addr, 32'h8000_0104);

        // redirect in REQ without handshake, then wrap past the top of memory
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        chk("wr_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("wr_req_addr", mem_req_addr, 32'hFFFF_FFFC);
        mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hAAAA_5555;
        tick();
        mem_rsp_valid = 1'b0;
        chk("wr_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wr_inst_err", {31'b0, inst_err}, 32'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("wr_next_addr", mem_req_addr, 32'h0000_0000);
        chk("wr_next_valid", {31'b0, mem_req_valid}, 32'd1);

        // redirect in REQ with same-cycle handshake goes to DROP
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("rr_drop_rsp_ready", {31'b0, mem_rsp_ready}, 32'd1);
        chk("rr_drop_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rr_drop_addr", mem_req_addr, 32'h0000_0200);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rr_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rr_req_addr", mem_req_addr, 32'h0000_0200);

        // redirect while holding an instruction
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_F00D;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rh_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("rh_inst_pc", inst_pc, 32'h0000_0200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        chk("rh_cleared", {31'b0, inst_valid}, 32'd0);
        chk("rh_req_addr", mem_req_addr, 32'h0000_0300);

        // reset during WAIT, with a stray response around the release
        tick();
        chk("rs_wait", {31'b0, mem_rsp_ready}, 32'd1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777_7777;
        rst = 1'b1;
        #1;
        chk("rs_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rs_rsp_ready", {31'b0, mem_rsp_ready}, 32'd0);
        chk("rs_addr", mem_req_addr, 32'h8000_0000);
        tick();
        rst = 1'b0;
        tick();
        chk("rs_req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("rs_req_addr", mem_req_addr, 32'h8000_0000);
        chk("rs_stale_ignored", {31'b0, inst_valid}, 32'd0);
        mem_rsp_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0055;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rs_inst", inst, 32'h0000_0055);
        chk("rs_inst_pc", inst_pc, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 SHALL have port mem_req_valid, output, 1, meaning a fetch request is presented.
REQ-005 SHALL have port mem_req_ready, input, 1, meaning memory accepts the request.
REQ-006 SHALL have port mem_req_addr, output, 32, the fetch address, word-aligned, bits[1:0]=0.
REQ-007 SHALL have port mem_rsp_valid, input, 1, meaning response data is valid.
REQ-008 SHALL have port mem_rsp_ready, output, 1, meaning the fetch unit accepts the response.
REQ-009 SHALL have port mem_rsp_data, input, 32, the instruction word.
REQ-010 SHALL have port mem_rsp_err, input, 1, the access-fault flag for the response.
REQ-011 SHALL have port redirect_valid, input, 1, a branch/trap redirect request.
REQ-012 SHALL have port redirect_pc, input, 32, the redirect target.
REQ-013 SHALL have port inst_valid, output, 1, meaning an instruction is offered downstream.
REQ-014 SHALL have port inst_ready, input, 1, meaning downstream accepts it.
REQ-015 SHALL have ports inst (32), inst_pc (32) and inst_err (1), outputs, holding the fetched word, its address and its fault flag.

Function
REQ-016 SHALL be a five-state FSM: IDLE, REQ, WAIT, HOLD, DROP; a handshake is valid&ready in the same cycle.
REQ-017 SHALL drive mem_req_valid=1 only in REQ, mem_rsp_ready=1 only in WAIT and DROP, and mem_req_addr=pc at all times.
REQ-018 SHALL move IDLE->REQ unconditionally on the first clock after reset release.
REQ-019 SHALL move REQ->WAIT on request handshake; otherwise it stays in REQ; address changes while unaccepted are permitted (memory samples only on handshake).
REQ-020 SHALL, in WAIT on response handshake without redirect, register inst<=mem_rsp_data, inst_pc<=pc, inst_err<=mem_rsp_err, set inst_valid=1, set pc<=pc+4 (mod 2^32) and enter HOLD.
REQ-021 SHALL hold inst, inst_pc and inst_err stable in HOLD until inst handshake, then clear inst_valid and enter REQ; minimum latency is request-accept to inst_valid = 1 cycle after response handshake.
REQ-022 SHALL, on redirect_valid, set pc<={redirect_pc[31:2],2'b00}, redirect having priority over every other event in the same cycle.
REQ-023 SHALL, on redirect in REQ without request handshake, stay in REQ; with a same-cycle request handshake, enter DROP.
REQ-024 SHALL, on redirect in WAIT, enter DROP if no response handshake occurs that cycle, or discard the response and enter REQ if it does; inst_valid stays 0.
REQ-025 SHALL, in DROP, discard the next response (no inst_valid), then enter REQ; redirect in DROP updates pc and remains in DROP.
REQ-026 SHALL, on redirect in HOLD, clear inst_valid and enter REQ; a same-cycle inst handshake counts as completed.
REQ-027 SHALL keep at most one outstanding memory request at any time.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_err=0, mem_req_valid=0, mem_rsp_ready=0.
REQ-029 SHALL abandon any in-flight transaction on reset mid-operation; a response arriving after reset release before a new request is ignored.

Verification
REQ-030 SHALL verify basic fetch: reset release, mem_req_ready=1, 1-cycle response 32'h00000013 -> inst=32'h00000013, inst_pc=32'h8000_0000; next request addr 32'h8000_0004.
REQ-031 SHALL verify backpressure: inst_ready=0 for 5 cycles -> inst_valid, inst and inst_pc stable, mem_req_valid=0 throughout.
REQ-032 SHALL verify redirect in WAIT: redirect_pc=32'h8000_0102 with 3-cycle response latency -> stale response dropped, next request addr 32'h8000_0100, no inst_valid for the stale word.
REQ-033 SHALL verify fault: mem_rsp_err=1 -> inst_err=1 with matching inst_pc; pc still advances by 4.
REQ-034 SHALL verify wrap: redirect to 32'hFFFF_FFFC, fetch completes -> next request addr 32'h0000_0000.
REQ-035 SHALL verify reset in WAIT: assert rst -> inst_valid=0, mem_rsp_ready=0 immediately; after release, first request addr equals RESET_PC.
